// File: rtl/offchip_mem_arbiter_pkg.sv
// Shared encodings and helpers for the off-chip memory line-port arbiter.
// LINE_BITS follows the cache-line-size define when one is provided.
`ifndef CACHE_LINE_BYTES
`define CACHE_LINE_BYTES 16
`endif

package offchip_mem_arbiter_pkg;

    localparam int unsigned CACHE_LINE_BYTES = `CACHE_LINE_BYTES;

    localparam int unsigned DEF_LINE_BITS = CACHE_LINE_BYTES * 8;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    function automatic logic [31:0] line_align(input logic [31:0] addr, input int unsigned offset_bits);
        logic [31:0] mask;
        mask = 32'hFFFF_FFFF << offset_bits;
        return addr & mask;
    endfunction

endpackage

// File: rtl/offchip_mem_arbiter_rr_arb2.sv
// Two-input round-robin picker with a D-side priority override.
// The last-grant pointer only moves when the owning transaction retires.
module rr_arb2
    import offchip_mem_arbiter_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   req_i,
    input  logic   req_d,
    input  logic   hi_pri_d,
    input  logic   upd_en,
    input  owner_t upd_owner,
    output logic   grant_valid,
    output owner_t grant_owner
);

    owner_t last_q;
    owner_t last_d;

    // Last-grant pointer register; D after reset so I wins the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= OWN_D;
        end else begin
            last_q <= last_d;
        end
    end

    // Pointer update on retirement.
    always_comb begin
        last_d = last_q;
        if (upd_en) begin
            last_d = upd_owner;
        end else begin
            last_d = last_q;
        end
    end

    // Pick: override first, then alternate on a tie, else the lone requester.
    always_comb begin
        grant_valid = req_i | req_d;
        grant_owner = OWN_I;
        if (hi_pri_d && req_d) begin
            grant_owner = OWN_D;
        end else if (req_i && req_d) begin
            grant_owner = (last_q == OWN_D) ? OWN_I : OWN_D;
        end else if (req_d) begin
            grant_owner = OWN_D;
        end else begin
            grant_owner = OWN_I;
        end
    end

endmodule

// File: rtl/offchip_mem_arbiter.sv
// Shares the off-chip line port between I-refill and D-refill/writeback with
// one outstanding transaction, round-robin grant and a timeout watchdog.
module offchip_mem_arbiter
    import offchip_mem_arbiter_pkg::*;
#(
    parameter int unsigned LINE_BITS      = DEF_LINE_BITS,
    parameter int unsigned OFFSET_BITS    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_req,
    input  logic [31:0]          i_addr,
    output logic                 i_ready,
    output logic                 i_err,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [31:0]          d_addr,
    input  logic [LINE_BITS-1:0] d_wdata,
    output logic                 d_ready,
    output logic                 d_err,
    output logic [LINE_BITS-1:0] rdata,
    output logic [31:0]          offchip_mem_addr,
    output logic [LINE_BITS-1:0] offchip_mem_wdata,
    output logic                 offchip_mem_read_en,
    output logic                 offchip_mem_write_en,
    input  logic [LINE_BITS-1:0] offchip_mem_data,
    input  logic                 offchip_mem_ready,
    output logic                 busy,
    output logic                 timeout_sticky
);

    localparam bit             TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t           state_q, state_d;
    owner_t               owner_q, owner_d;
    logic [31:0]          addr_q, addr_d;
    logic [LINE_BITS-1:0] wdata_q, wdata_d;
    logic [LINE_BITS-1:0] rdata_q, rdata_d;
    logic                 rd_en_q, rd_en_d;
    logic                 wr_en_q, wr_en_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 i_ready_q, i_ready_d;
    logic                 i_err_q, i_err_d;
    logic                 d_ready_q, d_ready_d;
    logic                 d_err_q, d_err_d;
    logic                 busy_q, busy_d;
    logic                 sticky_q, sticky_d;

    logic                 grant_valid_s;
    owner_t               grant_owner_s;
    logic                 arb_update_s;
    logic                 grant_we_s;

    rr_arb2 u_rr_arb2 (
        .clk         (clk),
        .rst         (rst),
        .req_i       (i_req),
        .req_d       (d_req),
        .hi_pri_d    (d_we),
        .upd_en      (arb_update_s),
        .upd_owner   (owner_q),
        .grant_valid (grant_valid_s),
        .grant_owner (grant_owner_s)
    );

    // State and datapath registers; reset drops strobes without a clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ARB_IDLE;
            owner_q   <= OWN_I;
            addr_q    <= 32'h0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            cnt_q     <= '0;
            i_ready_q <= 1'b0;
            i_err_q   <= 1'b0;
            d_ready_q <= 1'b0;
            d_err_q   <= 1'b0;
            busy_q    <= 1'b0;
            sticky_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            rd_en_q   <= rd_en_d;
            wr_en_q   <= wr_en_d;
            cnt_q     <= cnt_d;
            i_ready_q <= i_ready_d;
            i_err_q   <= i_err_d;
            d_ready_q <= d_ready_d;
            d_err_q   <= d_err_d;
            busy_q    <= busy_d;
            sticky_q  <= sticky_d;
        end
    end

    assign grant_we_s = (grant_owner_s == OWN_D) && d_we;

    // Next-state and datapath logic.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        rd_en_d      = rd_en_q;
        wr_en_d      = wr_en_q;
        cnt_d        = cnt_q;
        i_ready_d    = 1'b0;
        i_err_d      = 1'b0;
        d_ready_d    = 1'b0;
        d_err_d      = 1'b0;
        sticky_d     = sticky_q;
        arb_update_s = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (grant_valid_s) begin
                    owner_d = grant_owner_s;
                    if (grant_owner_s == OWN_D) begin
                        addr_d = line_align(d_addr, OFFSET_BITS);
                    end else begin
                        addr_d = line_align(i_addr, OFFSET_BITS);
                    end
                    if (grant_we_s) begin
                        wdata_d = d_wdata;
                    end else begin
                        wdata_d = wdata_q;
                    end
                    rd_en_d = ~grant_we_s;
                    wr_en_d = grant_we_s;
                    cnt_d   = '0;
                    state_d = ARB_BUSY;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_BUSY: begin
                // A ready arriving on the final count still completes cleanly.
                if (offchip_mem_ready) begin
                    rd_en_d = 1'b0;
                    wr_en_d = 1'b0;
                    if (rd_en_q) begin
                        rdata_d = offchip_mem_data;
                    end else begin
                        rdata_d = rdata_q;
                    end
                    i_ready_d = (owner_q == OWN_I);
                    d_ready_d = (owner_q == OWN_D);
                    state_d   = ARB_DONE;
                end else if (TO_EN && (cnt_q == TO_LAST)) begin
                    rd_en_d   = 1'b0;
                    wr_en_d   = 1'b0;
                    i_ready_d = (owner_q == OWN_I);
                    d_ready_d = (owner_q == OWN_D);
                    i_err_d   = (owner_q == OWN_I);
                    d_err_d   = (owner_q == OWN_D);
                    sticky_d  = 1'b1;
                    state_d   = ARB_DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ARB_BUSY;
                end
            end
            ARB_DONE: begin
                arb_update_s = 1'b1;
                cnt_d        = '0;
                state_d      = ARB_IDLE;
            end
            default: begin
                rd_en_d = 1'b0;
                wr_en_d = 1'b0;
                cnt_d   = '0;
                state_d = ARB_IDLE;
            end
        endcase

        busy_d = (state_d != ARB_IDLE);
    end

    assign i_ready              = i_ready_q;
    assign i_err                = i_err_q;
    assign d_ready              = d_ready_q;
    assign d_err                = d_err_q;
    assign rdata                = rdata_q;
    assign offchip_mem_addr     = addr_q;
    assign offchip_mem_wdata    = wdata_q;
    assign offchip_mem_read_en  = rd_en_q;
    assign offchip_mem_write_en = wr_en_q;
    assign busy                 = busy_q;
    assign timeout_sticky       = sticky_q;

endmodule

// File: tb/tb_offchip_mem_arbiter.sv
// Directed bench for offchip_mem_arbiter: a transaction table plus hand
// sequences for round-robin order, mid-transaction reset and stray ready.
module tb_offchip_mem_arbiter;

    localparam int LB = 128;

    logic          clk;
    logic          rst;
    logic          i_req;
    logic [31:0]   i_addr;
    logic          i_ready;
    logic          i_err;
    logic          d_req;
    logic          d_we;
    logic [31:0]   d_addr;
    logic [LB-1:0] d_wdata;
    logic          d_ready;
    logic          d_err;
    logic [LB-1:0] rdata;
    logic [31:0]   offchip_mem_addr;
    logic [LB-1:0] offchip_mem_wdata;
    logic          offchip_mem_read_en;
    logic          offchip_mem_write_en;
    logic [LB-1:0] offchip_mem_data;
    logic          offchip_mem_ready;
    logic          busy;
    logic          timeout_sticky;

    int n_vec  = 0;
    int n_fail = 0;

    offchip_mem_arbiter #(
        .LINE_BITS      (LB),
        .OFFSET_BITS    (4),
        .TIMEOUT_CYCLES (8),
        .CNT_W          (4)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .i_req                (i_req),
        .i_addr               (i_addr),
        .i_ready              (i_ready),
        .i_err                (i_err),
        .d_req                (d_req),
        .d_we                 (d_we),
        .d_addr               (d_addr),
        .d_wdata              (d_wdata),
        .d_ready              (d_ready),
        .d_err                (d_err),
        .rdata                (rdata),
        .offchip_mem_addr     (offchip_mem_addr),
        .offchip_mem_wdata    (offchip_mem_wdata),
        .offchip_mem_read_en  (offchip_mem_read_en),
        .offchip_mem_write_en (offchip_mem_write_en),
        .offchip_mem_data     (offchip_mem_data),
        .offchip_mem_ready    (offchip_mem_ready),
        .busy                 (busy),
        .timeout_sticky       (timeout_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          i_req;
        logic          d_req;
        logic          d_we;
        logic [31:0]   i_addr;
        logic [31:0]   d_addr;
        logic [LB-1:0] wdata;
        logic [LB-1:0] mem_data;
        int            delay;      // cycles before off-chip ready; -1 = never
        logic          exp_own_d;
        logic          exp_we;
        logic [31:0]   exp_addr;
        logic          exp_err;
        logic [LB-1:0] exp_rdata;
        logic          exp_sticky;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [LB-1:0] got, input logic [LB-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (offchip_mem_read_en || offchip_mem_write_en) begin
                ok = 1'b1;
                break;
            end
        end
        chk("grant_wait", {127'b0, ok}, {127'b0, 1'b1});
    endtask

    // Structural invariants, sampled away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            n_vec++;
            if ((i_ready && d_ready) || (offchip_mem_read_en && offchip_mem_write_en)) begin
                n_fail++;
                $display("FAIL overlap: rdy=%b%b en=%b%b required no overlap",
                         i_ready, d_ready, offchip_mem_read_en, offchip_mem_write_en);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          exp_d;
        logic [LB-1:0] last_rdata;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0, '0, {16{8'hA5}}, 2,
                    1'b0, 1'b0, 32'h0000_1230, 1'b0, {16{8'hA5}}, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_ABCF, '0, {4{32'h0123_4567}}, 0,
                    1'b1, 1'b0, 32'h0000_ABC0, 1'b0, {4{32'h0123_4567}}, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h0000_2000, 32'h8000_0040, {4{32'h1122_3344}},
                    {4{32'hDEAD_BEEF}}, 1,
                    1'b1, 1'b1, 32'h8000_0040, 1'b0, {4{32'h0123_4567}}, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_5550, '0, '0, -1,
                    1'b1, 1'b0, 32'h0000_5550, 1'b1, {4{32'h0123_4567}}, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, '0, {16{8'h5A}}, 7,
                    1'b0, 1'b0, 32'hFFFF_FFF0, 1'b0, {16{8'h5A}}, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h0000_7000, 32'h0000_3008, '0, {4{32'hCAFE_F00D}}, 0,
                    1'b1, 1'b0, 32'h0000_3000, 1'b0, {4{32'hCAFE_F00D}}, 1'b1};

        rst = 1'b0;
        i_req = 1'b0; i_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = '0;
        offchip_mem_data = '0; offchip_mem_ready = 1'b0;
        step(); step();

        chk("rst_strobes", {126'b0, offchip_mem_read_en, offchip_mem_write_en}, '0);
        chk("rst_ready", {124'b0, i_ready, i_err, d_ready, d_err}, '0);
        chk("rst_busy_sticky", {126'b0, busy, timeout_sticky}, '0);
        chk("rst_rdata", rdata, '0);
        chk("rst_addr", {96'b0, offchip_mem_addr}, '0);
        rst = 1'b1;
        step();

        // Both sides reading continuously: grants must alternate I, D, I, D.
        i_addr = 32'h0000_0100; d_addr = 32'h0000_0200; d_we = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        for (int g = 0; g < 4; g++) begin
            exp_d = g[0];
            wait_grant();
            chk("rr_addr", {96'b0, offchip_mem_addr}, {96'b0, exp_d ? 32'h0000_0200 : 32'h0000_0100});
            offchip_mem_ready = 1'b1;
            offchip_mem_data  = {4{32'h0, 32'(g)}};
            step();
            offchip_mem_ready = 1'b0;
            chk("rr_ready", {126'b0, i_ready, d_ready}, {126'b0, ~exp_d, exp_d});
            if (g == 3) begin
                i_req = 1'b0; d_req = 1'b0;
            end else if (exp_d) begin
                d_req = 1'b0;
            end else begin
                i_req = 1'b0;
            end
            step();
            if (g != 3) begin
                if (exp_d) d_req = 1'b1;
                else       i_req = 1'b1;
            end
        end
        step();

        for (int v = 0; v < NV; v++) begin
            i_req   = vecs[v].i_req;
            d_req   = vecs[v].d_req;
            d_we    = vecs[v].d_we;
            i_addr  = vecs[v].i_addr;
            d_addr  = vecs[v].d_addr;
            d_wdata = vecs[v].wdata;
            step();
            chk($sformatf("v%0d_read_en", v), {127'b0, offchip_mem_read_en}, {127'b0, ~vecs[v].exp_we});
            chk($sformatf("v%0d_write_en", v), {127'b0, offchip_mem_write_en}, {127'b0, vecs[v].exp_we});
            chk($sformatf("v%0d_addr", v), {96'b0, offchip_mem_addr}, {96'b0, vecs[v].exp_addr});
            chk($sformatf("v%0d_busy", v), {127'b0, busy}, {127'b0, 1'b1});
            if (vecs[v].exp_we) begin
                chk($sformatf("v%0d_wdata", v), offchip_mem_wdata, vecs[v].wdata);
            end
            if (vecs[v].delay >= 0) begin
                repeat (vecs[v].delay) step();
                offchip_mem_ready = 1'b1;
                offchip_mem_data  = vecs[v].mem_data;
                step();
                offchip_mem_ready = 1'b0;
            end else begin
                int n;
                n = 0;
                while (n < 20 && !(i_ready || d_ready)) begin
                    step();
                    n++;
                end
                chk($sformatf("v%0d_timeout_len", v), LB'(n), LB'(8));
            end
            chk($sformatf("v%0d_i_ready", v), {127'b0, i_ready}, {127'b0, ~vecs[v].exp_own_d});
            chk($sformatf("v%0d_d_ready", v), {127'b0, d_ready}, {127'b0, vecs[v].exp_own_d});
            chk($sformatf("v%0d_i_err", v), {127'b0, i_err}, {127'b0, vecs[v].exp_err & ~vecs[v].exp_own_d});
            chk($sformatf("v%0d_d_err", v), {127'b0, d_err}, {127'b0, vecs[v].exp_err & vecs[v].exp_own_d});
            chk($sformatf("v%0d_rdata", v), rdata, vecs[v].exp_rdata);
            chk($sformatf("v%0d_sticky", v), {127'b0, timeout_sticky}, {127'b0, vecs[v].exp_sticky});
            chk($sformatf("v%0d_strobes_off", v), {126'b0, offchip_mem_read_en, offchip_mem_write_en}, '0);
            i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
            step();
            chk($sformatf("v%0d_pulse_once", v), {126'b0, i_ready, d_ready}, '0);
            step();
        end

        // Reset pulled low in the middle of a read, with the request held.
        i_req = 1'b1; i_addr = 32'h4444_4448;
        step();
        chk("mid_rst_pre_en", {127'b0, offchip_mem_read_en}, {127'b0, 1'b1});
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_strobes", {126'b0, offchip_mem_read_en, offchip_mem_write_en}, '0);
        chk("mid_rst_busy", {127'b0, busy}, '0);
        chk("mid_rst_ready", {126'b0, i_ready, d_ready}, '0);
        chk("mid_rst_sticky", {127'b0, timeout_sticky}, '0);
        chk("mid_rst_rdata", rdata, '0);
        #1 rst = 1'b1;
        step();
        chk("post_rst_grant", {127'b0, offchip_mem_read_en}, {127'b0, 1'b1});
        chk("post_rst_addr", {96'b0, offchip_mem_addr}, {96'b0, 32'h4444_4440});
        offchip_mem_ready = 1'b1;
        offchip_mem_data  = {4{32'h7777_1111}};
        step();
        offchip_mem_ready = 1'b0;
        chk("post_rst_ready", {126'b0, i_ready, i_err}, {126'b0, 1'b1, 1'b0});
        chk("post_rst_rdata", rdata, {4{32'h7777_1111}});
        i_req = 1'b0;
        step(); step();

        // Stray off-chip ready while idle must be ignored.
        last_rdata = {4{32'h7777_1111}};
        offchip_mem_ready = 1'b1;
        offchip_mem_data  = {16{8'hEE}};
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("idle_rdy%0d_ready", c), {126'b0, i_ready, d_ready}, '0);
            chk($sformatf("idle_rdy%0d_busy", c), {127'b0, busy}, '0);
            chk($sformatf("idle_rdy%0d_rdata", c), rdata, last_rdata);
        end
        offchip_mem_ready = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/offchip_mem_arbiter.md
Name: offchip_mem_arbiter

Overview:
Shares the single off-chip memory line port between two requesters: the instruction-cache refill path (read only) and the data-cache refill/writeback path (read or write).
- Sits between the memory controller's per-cache refill FSMs and the off-chip memory interface.
- Replaces ad-hoc busy-flag sharing with registered round-robin arbitration, one outstanding transaction, and a timeout watchdog.

Parameters:
LINE_BITS, 128, off-chip line width in bits (cache line size × 8).
OFFSET_BITS, 4, low address bits forced to zero (line-aligned).
TIMEOUT_CYCLES, 1024, max cycles waiting for off-chip ready before aborting; 0 disables.
CNT_W, 11, width of timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-low
i_req  input  1  I-side request, held high until i_ready
i_addr  input  32  I-side line address
i_ready  output  1  one-cycle pulse: I transaction finished
i_err  output  1  valid with i_ready: transaction aborted by timeout
d_req  input  1  D-side request, held high until d_ready
d_we  input  1  D-side: 1 = writeback, 0 = refill read
d_addr  input  32  D-side line address
d_wdata  input  LINE_BITS  D-side writeback line
d_ready  output  1  one-cycle pulse: D transaction finished
d_err  output  1  valid with d_ready: timeout abort
rdata  output  LINE_BITS  captured off-chip line, valid from the ready pulse until the next completion
offchip_mem_addr  output  32  registered line-aligned address
offchip_mem_wdata  output  LINE_BITS  registered write line
offchip_mem_read_en  output  1  read strobe, level, held until offchip_mem_ready
offchip_mem_write_en  output  1  write strobe, level, held until offchip_mem_ready
offchip_mem_data  input  LINE_BITS  read line, valid with offchip_mem_ready
offchip_mem_ready  input  1  off-chip completion
busy  output  1  high in any non-IDLE state
timeout_sticky  output  1  set on any timeout; cleared only by reset

Behaviour:
Reset (rst low, asynchronous):
- All outputs 0; rdata 0.
- State IDLE; last-grant pointer = D, so I wins the first tie.

FSM states:
- IDLE
  - Arbitrate among requests sampled this cycle.
  - Grant: register addr with low OFFSET_BITS cleared, wdata (D write only) and direction.
  - Set read_en or write_en; go to BUSY. Strobe is visible the cycle after the req is seen.
- BUSY
  - Timeout counter increments each cycle.
  - On offchip_mem_ready:
    - drop both strobes;
    - capture offchip_mem_data into rdata (reads only; writes leave rdata unchanged);
    - go to DONE.
  - If counter reaches TIMEOUT_CYCLES−1 without ready:
    - drop strobes;
    - set err for the owner and set timeout_sticky;
    - go to DONE.
- DONE
  - Pulse owner's ready (with err if aborted) for exactly one cycle.
  - Update last-grant pointer; clear counter; go to IDLE.
  - Minimum re-grant gap is one IDLE cycle, so a requester's own dropping req is seen before re-arbitration.

Arbitration priority, highest first:
1. D writeback (d_req & d_we) always wins, so a dirty line is evicted before its refill.
2. Otherwise, when both request, grant the side not granted last.
3. A single requester is granted immediately.

Boundary rules:
- Fixed latency: req to strobe = 1 cycle; offchip_mem_ready to requester ready = 1 cycle.
- Req dropped mid-transaction: transaction completes and ready still pulses; requester ignores it.
- offchip_mem_ready while IDLE or DONE: ignored.
- offchip_mem_ready on the same cycle the timeout count is reached: ready wins, no error.
- Reset mid-BUSY: strobes drop immediately (asynchronous); no ready pulse is generated.
- Never both strobes high; never both ready pulses in one cycle.

Decomposition:
- Shared package/include: state encodings ARB_IDLE/ARB_BUSY/ARB_DONE and owner encoding OWN_I/OWN_D.
- Shared package/include: LINE_BITS derivation from the existing cache-line-size define.
- Sub-module rr_arb2: 2-input round-robin picker with a high-priority override input and a registered last-grant pointer.
- The FSM, counter and datapath registers stay in the top module.

Test Plan:
1. Only i_req, i_addr=0x0000_1234; off-chip ready 3 cycles later with data 0xA5…A5:
   - read_en high one cycle after req;
   - offchip_mem_addr=0x0000_1230;
   - i_ready pulses once; rdata=0xA5…A5; i_err=0.
2. i_req and d_req(read) asserted together from reset, each re-requesting after completion:
   - grant order I, D, I, D;
   - ready pulses never overlap.
3. i_req pending; d_req with d_we=1, d_addr=0x8000_0040, d_wdata=0x1122…:
   - write_en wins with the same addr/wdata;
   - rdata unchanged;
   - I granted after d_ready.
4. TIMEOUT_CYCLES=8, d_req read, off-chip never ready:
   - read_en drops after 8 cycles;
   - d_ready and d_err pulse together; timeout_sticky=1;
   - next i_req is still served.
5. rst pulled low during BUSY:
   - strobes and busy go 0 without a clock edge; no ready pulse;
   - after release, a pending i_req is granted normally.
6. offchip_mem_ready asserted while IDLE with no request:
   - no ready pulse, no state change, rdata unchanged.
